// File: rtl/move_expander_if.sv
// Move stream handshake between the move expander and the downstream move selector.
// One move is transferred on each cycle where move_valid and move_ready are both high.
interface move_expander_if;
    logic       move_valid;
    logic       move_ready;
    logic [3:0] move_piece;
    logic [2:0] move_from_row;
    logic [2:0] move_from_col;
    logic [2:0] move_to_row;
    logic [2:0] move_to_col;

    modport master (
        output move_valid, move_piece, move_from_row, move_from_col, move_to_row, move_to_col,
        input  move_ready
    );

    modport slave (
        input  move_valid, move_piece, move_from_row, move_from_col, move_to_row, move_to_col,
        output move_ready
    );
endinterface

// File: rtl/move_expander.sv
// Expands the packed pawn/rook move set into a stream of concrete (piece, from, to) moves.
// Scans one candidate per cycle and reports the emitted-move count when the scan completes.
module move_expander #(
    parameter int unsigned NUM_PAWNS = 8,
    parameter int unsigned NUM_ROOKS = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              player_i,
    input  logic [95:0]       location_vector_white_i,
    input  logic [95:0]       location_vector_black_i,
    input  logic [15:0]       alive_vector_white_i,
    input  logic [15:0]       alive_vector_black_i,
    input  logic [112:0]      move_set_i,
    move_expander_if.master   mv,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  move_count_o,
    output logic              range_err_o
);

    localparam logic [3:0] PawnLimit = 4'(NUM_PAWNS);
    localparam logic [3:0] LastPiece = 4'(NUM_PAWNS + NUM_ROOKS - 1);

    typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_e;

    state_e             state_q;
    logic               player_q;
    logic [95:0]        loc_q;
    logic [15:0]        alive_q;
    logic [112:57]      move_set_q;
    logic [3:0]         piece_q;
    logic [1:0]         field_q;
    logic [2:0]         step_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               valid_q, busy_q, done_q, err_q;
    logic [3:0]         out_piece_q;
    logic [2:0]         fr_q, fc_q, tr_q, tc_q;
    logic [CNT_W-1:0]   count_q;

    logic               is_pawn, alive, present, oob, field_end, last;
    logic [3:0]         pid, row4, col4, dir, j4, dst_row, dst_col;
    logic [6:0]         pawn_base, rook_base, loc_base;
    logic [3:0]         pawn_bits;
    logic [11:0]        rook_field;
    logic [5:0]         loc;
    logic [2:0]         rook_cnt, eff_cnt;
    logic [3:0]         piece_d;
    logic [1:0]         field_d;
    logic [2:0]         step_d;

    // Candidate decode for the current scan pointer (piece, field, step).
    always_comb begin
        is_pawn    = piece_q < PawnLimit;
        pid        = 4'd15 - piece_q;
        pawn_base  = 7'd112 - {1'b0, piece_q, 2'b00};
        rook_base  = piece_q[0] ? 7'd68 : 7'd80;
        pawn_bits  = move_set_q[pawn_base -: 4];
        rook_field = move_set_q[rook_base -: 12];
        loc_base   = 7'(pid) * 7'd6;
        loc        = loc_q[loc_base +: 6];
        alive      = alive_q[pid];
        case (field_q)
            2'd0:    rook_cnt = rook_field[11:9];
            2'd1:    rook_cnt = rook_field[8:6];
            2'd2:    rook_cnt = rook_field[5:3];
            default: rook_cnt = rook_field[2:0];
        endcase
        eff_cnt = alive ? rook_cnt : 3'd0;
        row4    = {1'b0, loc[5:3]};
        col4    = {1'b0, loc[2:0]};
        dir     = player_q ? 4'd1 : 4'hf;
        j4      = {1'b0, step_q};
        dst_row = row4;
        dst_col = col4;
        if (is_pawn) begin
            present = alive & pawn_bits[2'd3 - field_q];
            case (field_q)
                2'd0:    dst_row = row4 + dir;
                2'd1:    dst_row = row4 + dir + dir;
                2'd2:    begin dst_row = row4 + dir; dst_col = col4 - 4'd1; end
                default: begin dst_row = row4 + dir; dst_col = col4 + 4'd1; end
            endcase
        end else begin
            present = eff_cnt != 3'd0;
            case (field_q)
                2'd0:    dst_col = col4 - j4;
                2'd1:    dst_col = col4 + j4;
                2'd2:    dst_row = row4 + j4;
                default: dst_row = row4 - j4;
            endcase
        end
        // Any 4-bit result with bit 3 set lies outside 0..7 signed or unsigned.
        oob       = dst_row[3] | dst_col[3];
        field_end = is_pawn || (eff_cnt == 3'd0) || (step_q == eff_cnt);
        last      = field_end && (field_q == 2'd3) && (piece_q == LastPiece);
        piece_d   = piece_q;
        field_d   = field_q;
        step_d    = step_q + 3'd1;
        if (field_end) begin
            step_d  = 3'd1;
            field_d = field_q + 2'd1;
            if (field_q == 2'd3) piece_d = piece_q + 4'd1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            player_q    <= 1'b0;
            loc_q       <= '0;
            alive_q     <= '0;
            move_set_q  <= '0;
            piece_q     <= '0;
            field_q     <= '0;
            step_q      <= 3'd1;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_piece_q <= '0;
            fr_q        <= '0;
            fc_q        <= '0;
            tr_q        <= '0;
            tc_q        <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        player_q   <= player_i;
                        loc_q      <= player_i ? location_vector_white_i : location_vector_black_i;
                        alive_q    <= player_i ? alive_vector_white_i : alive_vector_black_i;
                        move_set_q <= move_set_i[112:57];
                        piece_q    <= '0;
                        field_q    <= '0;
                        step_q     <= 3'd1;
                        cnt_q      <= '0;
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StScan;
                    end
                end
                StScan: begin
                    piece_q <= piece_d;
                    field_q <= field_d;
                    step_q  <= step_d;
                    if (present && oob) err_q <= 1'b1;
                    if (present && !oob) begin
                        valid_q     <= 1'b1;
                        out_piece_q <= pid;
                        fr_q        <= row4[2:0];
                        fc_q        <= col4[2:0];
                        tr_q        <= dst_row[2:0];
                        tc_q        <= dst_col[2:0];
                        last_q      <= last;
                        state_q     <= StEmit;
                    end else if (last) begin
                        state_q <= StDone;
                    end
                end
                StEmit: begin
                    if (mv.move_ready) begin
                        valid_q <= 1'b0;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        state_q <= last_q ? StDone : StScan;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    count_q <= cnt_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mv.move_valid    = valid_q;
    assign mv.move_piece    = out_piece_q;
    assign mv.move_from_row = fr_q;
    assign mv.move_from_col = fc_q;
    assign mv.move_to_row   = tr_q;
    assign mv.move_to_col   = tc_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign move_count_o     = count_q;
    assign range_err_o      = err_q;

endmodule

// File: tb/tb_move_expander.sv
// Directed bench for move_expander: reset, empty scan timing, pawn/rook expansion, stalls,
// off-board drops and dead pieces.
module tb_move_expander;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, player;
    logic [95:0]  locw, locb;
    logic [15:0]  alw, alb;
    logic [112:0] mset;
    logic         busy, done, rerr;
    logic [7:0]   mcount;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    move_expander_if mif ();

    move_expander #(.NUM_PAWNS(8), .NUM_ROOKS(2), .CNT_W(8)) dut (
        .clock_i                 (clk),
        .reset_ni                (rst_n),
        .start_i                 (start),
        .player_i                (player),
        .location_vector_white_i (locw),
        .location_vector_black_i (locb),
        .alive_vector_white_i    (alw),
        .alive_vector_black_i    (alb),
        .move_set_i              (mset),
        .mv                      (mif.master),
        .busy_o                  (busy),
        .done_o                  (done),
        .move_count_o            (mcount),
        .range_err_o             (rerr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " valid"}, 32'(mif.move_valid), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " range_err"}, 32'(rerr), 0);
        chk({tag, " count"}, 32'(mcount), 0);
        chk({tag, " fields"}, 32'({mif.move_piece, mif.move_from_row, mif.move_from_col,
                                   mif.move_to_row, mif.move_to_col}), 0);
    endtask

    task automatic pulse_start(input logic pl);
        @(negedge clk);
        player = pl;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic expect_move(input string tag, input int pc, input int fr, input int fc,
                               input int tr, input int tc, input int stall, input logic poke);
        int t = 0;
        mif.move_ready = 1'b0;
        while (mif.move_valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i <= stall; i++) begin
            chk({tag, " valid"}, 32'(mif.move_valid), 1);
            chk({tag, " move"}, 32'({mif.move_piece, mif.move_from_row, mif.move_from_col,
                                     mif.move_to_row, mif.move_to_col}),
                32'({pc[3:0], fr[2:0], fc[2:0], tr[2:0], tc[2:0]}));
            if (i < stall) begin
                start = poke;
                @(negedge clk);
            end
        end
        start          = 1'b0;
        mif.move_ready = 1'b1;
        @(negedge clk);
        mif.move_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles, input int exp_count,
                             input logic exp_err);
        int   t   = 0;
        logic saw = 1'b0;
        while (done !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
            if (mif.move_valid === 1'b1) saw = 1'b1;
        end
        chk({tag, " done"}, 32'(done), 1);
        if (exp_cycles >= 0) chk({tag, " latency"}, 32'(t), 32'(exp_cycles));
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " count"}, 32'(mcount), 32'(exp_count));
        chk({tag, " range_err"}, 32'(rerr), 32'(exp_err));
        chk({tag, " extra valid"}, 32'(saw), 0);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        player         = 1'b1;
        locw           = '0;
        locb           = '0;
        alw            = 16'hffff;
        alb            = 16'hffff;
        mset           = '0;
        mif.move_ready = 1'b0;
        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Empty move set: 40 scan cycles plus the done cycle.
        pulse_start(1'b1);
        chk("empty busy", 32'(busy), 1);
        wait_done("empty", 41, 0, 1'b0);

        // Reset in the middle of an emit.
        locw[6*15 +: 6] = {3'd1, 3'd4};
        mset[112 -: 4]  = 4'b1100;
        pulse_start(1'b1);
        for (int i = 0; i < 100 && mif.move_valid !== 1'b1; i++) @(negedge clk);
        chk("pre-reset valid", 32'(mif.move_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post reset done", 32'(done), 0);

        // Pawn pushes, first move stalled with stray start pulses.
        pulse_start(1'b1);
        expect_move("pawn m1", 15, 1, 4, 2, 4, 5, 1'b1);
        expect_move("pawn m2", 15, 1, 4, 3, 4, 0, 1'b0);
        wait_done("pawn", -1, 2, 1'b0);

        // Black rook; inputs changed after start must not matter.
        mset             = '0;
        mset[80 -: 12]   = 12'b000_010_000_001;
        locb[6*7 +: 6]   = {3'd7, 3'd0};
        locw[6*7 +: 6]   = {3'd3, 3'd3};
        pulse_start(1'b0);
        player = 1'b1;
        locb   = '0;
        expect_move("rook m1", 7, 7, 0, 7, 1, 0, 1'b0);
        expect_move("rook m2", 7, 7, 0, 7, 2, 1, 1'b0);
        expect_move("rook m3", 7, 7, 0, 6, 0, 0, 1'b0);
        wait_done("rook", -1, 3, 1'b0);

        // Pawn on column 0 capturing left goes off-board.
        mset             = '0;
        locw             = '0;
        locw[6*14 +: 6]  = {3'd1, 3'd0};
        mset[108 -: 4]   = 4'b1010;
        pulse_start(1'b1);
        expect_move("edge m1", 14, 1, 0, 2, 0, 0, 1'b0);
        wait_done("edge", -1, 1, 1'b1);

        // Dead pawn and dead rook with nonzero fields emit nothing at full cycle cost.
        mset             = '0;
        locw             = '0;
        alw              = 16'hdfbf;
        locw[6*13 +: 6]  = {3'd1, 3'd2};
        locw[6*6 +: 6]   = {3'd3, 3'd3};
        mset[104 -: 4]   = 4'b1000;
        mset[68 -: 12]   = 12'b001_000_000_000;
        pulse_start(1'b1);
        wait_done("dead", 41, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/move_expander.md
Name: move_expander

Overview:
- Consumes the packed `moveSet` vector produced by the move generator and expands it into a stream of concrete moves: piece ID, from-square and to-square.
- Emits one move per valid/ready handshake to the downstream move selector/evaluator, then pulses `done` with the total count.
- Sits directly after move generation in the engine pipeline.

Parameters:
- NUM_PAWNS, 8, pawn slots decoded (IDs 15 down to 8).
- NUM_ROOKS, 2, rook slots decoded (IDs 7 down to 6).
- CNT_W, 8, width of `move_count`.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to expand; sampled only in IDLE.
- player  input  1  1 = white, 0 = black; selects vectors and pawn direction.
- locationVectorWhite  input  96  6 bits per piece ID p at [6p+5:6p]; row = [6p+5:6p+3], col = [6p+2:6p].
- locationVectorBlack  input  96  same format as white.
- aliveVectorWhite  input  16  bit p = piece p alive.
- aliveVectorBlack  input  16  same format as white.
- moveSet  input  113  pawn k (k=0..7, ID 15-k) at [112-4k -: 4]; rook r (r=0..1, ID 7-r) at [80-12r -: 12]; [56:0] ignored.
- move_valid  output  1  move fields valid.
- move_ready  input  1  downstream accepts move.
- move_piece  output  4  piece ID.
- move_from_row, move_from_col  output  3 each  origin square.
- move_to_row, move_to_col  output  3 each  destination square.
- busy  output  1  high from start acceptance until `done`.
- done  output  1  single-cycle pulse at end of expansion.
- move_count  output  CNT_W  moves emitted in last run; held until next start.
- range_err  output  1  sticky per run; set if any encoded move lands off-board.

Behaviour:
- Reset (async, active-low): state = IDLE. `move_valid`, `busy`, `done`, `range_err` = 0. `move_count` = 0. All move fields = 0.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - On clock edge with `start` = 1: latch `player`, the selected location vector, the selected alive vector and `moveSet`.
  - Clear the count and `range_err`, set `busy`, go to SCAN.
  - `start` in any other state is ignored.
  - Inputs may change after latching without effect.
- SCAN evaluates exactly one candidate per cycle, in fixed order:
  - Piece order: pawns ID15..ID8, then R1 (ID7), then R2 (ID6).
  - Per pawn, bits [3],[2],[1],[0]. Bit [3] = forward one (row+d). Bit [2] = forward two (row+2d). Bit [1] = capture col-1, row+d. Bit [0] = capture col+1, row+d. d = +1 white, -1 black.
  - Per rook, fields in order left [11:9] (col-j), right [8:6] (col+j), up [5:3] (row+j), down [2:0] (row-j). j steps 1..count ascending.
  - Cycle cost: one cycle per step; a zero-count field costs one cycle.
  - Dead piece: its 4 pawn bits / 4 rook fields each still cost one cycle, and nothing is emitted.
  - Cleared pawn bit: one cycle, no emit.
- Destination arithmetic: done in 4-bit signed. A result outside 0..7 drops the move and sets `range_err`. Only in-range moves are emitted.
- Emitting candidate: outputs are registered, so `move_valid` rises the cycle after the SCAN evaluation; state = EMIT.
- EMIT:
  - Fields are held stable while `move_valid` = 1 and `move_ready` = 0.
  - On `move_valid` & `move_ready`: increment count, go to SCAN for the next candidate. `move_valid` drops in that cycle unless the next candidate emits; no back-to-back skipping.
- After the final candidate: DONE for one cycle. `done` = 1, `busy` = 0 on the following edge, `move_count` updated. Then IDLE.
- Count saturates at 2^CNT_W-1.
- Reset asserted mid-run: immediate return to reset values; no partial `done`.

Test Plan:
- Reset with run active (mid-EMIT, `move_valid` = 1) -> all outputs 0 asynchronously; IDLE; next start behaves normally.
- `moveSet` = 0, all alive, white -> no `move_valid`; `done` pulses once exactly 41 cycles after start sampled (40 SCAN + DONE); `move_count` = 0, `range_err` = 0.
- White, P1 (ID15) at row1 col4, pawn field 4'b1100, rest 0 -> two moves: (15, 1,4 -> 2,4) then (15, 1,4 -> 3,4); `move_count` = 2.
- Black, R1 (ID7) at row7 col0, rook field left=0 right=2 up=0 down=1 -> moves in order (7, 7,0->7,1), (7, 7,0->7,2), (7, 7,0->6,0); count = 3.
- `move_ready` held low 5 cycles on first move -> fields constant for all 5 cycles, no skipped or duplicated moves; `start` pulses during run are ignored.
- White pawn at col0 with bit [1] set -> move dropped, `range_err` = 1, count excludes it; dead piece with nonzero field -> nothing emitted.
